// File: rtl/systolic_seq_pkg.sv
// Shared types and constants for the corelet compute-pass sequencer.
package systolic_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_FETCH,
    W_LOAD,
    A_STREAM,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int AW_AW = 7;
  localparam int OP_AW = 9;
  localparam int AW_DW = 32;

  localparam int DEF_ROW      = 8;
  localparam int DEF_COL      = 8;
  localparam int DEF_PSUM_BW  = 16;
  localparam int DEF_W_BASE   = 0;
  localparam int DEF_NUM_W    = 8;
  localparam int DEF_A_BASE   = 8;
  localparam int DEF_NUM_A    = 36;
  localparam int DEF_OP_BASE  = 0;
  localparam int DEF_NUM_OUT  = 16;

  // Bits needed for a counter that runs 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sram_rd_stream.sv
// Base/count SRAM read address generator. Issues one read per cycle while
// enabled and not stalled; a one-stage valid pipe marks the cycle the read
// data arrives (SRAM read latency is one cycle).
module sram_rd_stream
  import systolic_seq_pkg::*;
#(
  parameter int ADDR_W = AW_AW,
  parameter int BASE   = 0,
  parameter int COUNT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr,
  output logic              cen,
  output logic              wr,
  output logic              all_issued
);

  localparam int CW = cnt_width(COUNT);

  logic [CW-1:0] cnt;
  logic          issue;

  // Read issue decode; address is held at base+count while stalled.
  always_comb begin
    all_issued = (cnt == CW'(COUNT));
    issue      = en && !stall && !all_issued;
    cen        = !issue;
    addr       = ADDR_W'(BASE) + ADDR_W'(cnt);
  end

  // Issued-read counter and read-data valid pipe.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
      wr  <= 1'b0;
    end else begin
      wr <= issue;
      if (issue) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Corelet compute-pass sequencer: weight fetch and load, activation stream,
// OFIFO drain into OP SRAM. Optional cycle counter under SEQ_CYCLE_CNT_EN.
module systolic_seq_ctrl
  import systolic_seq_pkg::*;
#(
  parameter int row      = DEF_ROW,
  parameter int col      = DEF_COL,
  parameter int PSUM_BW  = DEF_PSUM_BW,
  parameter int W_BASE   = DEF_W_BASE,
  parameter int NUM_W    = DEF_NUM_W,
  parameter int A_BASE   = DEF_A_BASE,
  parameter int NUM_A    = DEF_NUM_A,
  parameter int LOAD_CYC = col + row,
  parameter int OP_BASE  = DEF_OP_BASE,
  parameter int NUM_OUT  = DEF_NUM_OUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     seq_begin,
  output logic                     seq_done,
  output logic [AW_AW-1:0]         AW_addr,
  output logic                     AW_cen,
  output logic                     AW_wen,
  output logic                     l0_wr,
  input  logic                     l0_afull,
  input  logic                     l0_empty,
  output logic                     l0_rd,
  output logic                     load,
  output logic                     execute,
  input  logic                     ofifo_valid,
  input  logic [col*PSUM_BW-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic [OP_AW-1:0]         OP_addr,
  output logic [col*PSUM_BW-1:0]   OP_d,
  output logic                     OP_cen,
  output logic                     OP_wen,
  output logic                     busy
`ifdef SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]              cycle_cnt
`endif
);

  localparam int LCW  = cnt_width(LOAD_CYC);
  localparam int OCW  = cnt_width(NUM_OUT);
  localparam int OCW1 = OCW + 1;

  seq_state_t state, state_nxt;

  logic             start;
  logic [LCW-1:0]   lcnt;
  logic [OCW-1:0]   ocnt;
  logic             op_pend;
  logic             writer_on;

  logic [AW_AW-1:0] w_addr, a_addr;
  logic             w_cen, a_cen;
  logic             w_wr, a_wr;
  logic             w_all, a_all;

  assign start     = (state == IDLE) && seq_begin;
  assign writer_on = (state == A_STREAM) || (state == DRAIN);

  sram_rd_stream #(
    .ADDR_W (AW_AW),
    .BASE   (W_BASE),
    .COUNT  (NUM_W)
  ) u_w_stream (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .en         (state == W_FETCH),
    .stall      (l0_afull),
    .addr       (w_addr),
    .cen        (w_cen),
    .wr         (w_wr),
    .all_issued (w_all)
  );

  sram_rd_stream #(
    .ADDR_W (AW_AW),
    .BASE   (A_BASE),
    .COUNT  (NUM_A)
  ) u_a_stream (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .en         (state == A_STREAM),
    .stall      (l0_afull),
    .addr       (a_addr),
    .cen        (a_cen),
    .wr         (a_wr),
    .all_issued (a_all)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and PE/L0 instruction decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    execute   = 1'b0;
    l0_rd     = 1'b0;
    seq_done  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (seq_begin) state_nxt = W_FETCH;
      end
      W_FETCH: begin
        // All reads issued and the final one landing in L0 this cycle.
        if (w_all && w_wr) state_nxt = W_LOAD;
      end
      W_LOAD: begin
        load  = 1'b1;
        l0_rd = !l0_empty;
        if (lcnt == LCW'(LOAD_CYC - 1)) state_nxt = A_STREAM;
      end
      A_STREAM: begin
        execute = !l0_empty;
        l0_rd   = !l0_empty;
        if (a_all && !a_wr && l0_empty) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (ocnt == OCW'(NUM_OUT)) state_nxt = DONE;
      end
      DONE: begin
        seq_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM port drive: AW is read-only; OP writes the cycle after each pop.
  always_comb begin
    AW_wen   = 1'b1;
    AW_cen   = w_cen & a_cen;
    l0_wr    = w_wr | a_wr;
    AW_addr  = '0;
    if (state == W_FETCH)  AW_addr = w_addr;
    if (state == A_STREAM) AW_addr = a_addr;
    // Pending write counts against the quota so no extra row is popped.
    ofifo_rd = writer_on && ofifo_valid &&
               ((OCW1'(ocnt) + OCW1'(op_pend)) < OCW1'(NUM_OUT));
    OP_cen   = !op_pend;
    OP_wen   = !op_pend;
    OP_addr  = op_pend ? (OP_AW'(OP_BASE) + OP_AW'(ocnt)) : '0;
  end

  // Load-cycle and output-word counters.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      lcnt <= '0;
      ocnt <= '0;
    end else begin
      if (state == W_LOAD) lcnt <= lcnt + LCW'(1);
      if (op_pend)         ocnt <= ocnt + OCW'(1);
    end
  end

  // Pop-to-write pipe: capture popped OFIFO row for next-cycle OP write.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_pend <= 1'b0;
      OP_d    <= '0;
    end else begin
      op_pend <= ofifo_rd;
      if (ofifo_rd) OP_d <= ofifo_out;
    end
  end

`ifdef SEQ_CYCLE_CNT_EN
  // Saturating count of non-IDLE cycles for the current/last pass.
  always_ff @(posedge clk) begin
    if (reset || start)                        cycle_cnt <= '0;
    else if (state != IDLE && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 16'd1;
  end
`endif

endmodule
